// File: rtl/imem_loader.sv
// Instruction-memory writer: parses a framed little-endian byte stream into 32-bit words,
// writes them through a single port, and holds the core in reset until a load checks out.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_e                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic [15:0]           len_q, len_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           word_q, word_d;
  logic [7:0]            chk_q, chk_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  core_reset_q, core_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;

  logic                  accept;
  logic [15:0]           len_full;
  logic                  last_word;

  always_comb begin
    // NOTE: every _d starts from its _q (or idle value) so no path through the case infers a latch.
    state_d      = state_q;
    len_d        = len_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    chk_d        = chk_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    core_reset_d = core_reset_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    words_d      = words_q;

    accept    = in_valid && in_ready_q;
    len_full  = {in_data, len_q[7:0]};
    last_word = (17'(words_q) + 17'd1) == {1'b0, len_q};

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d      = S_LEN_LO;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
          core_reset_d = 1'b1;
          words_d      = '0;
          chk_d        = '0;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          len_d   = {8'h00, in_data};
          state_d = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        if (accept) begin
          len_d      = len_full;
          byte_idx_d = 2'd0;
          if (len_full == 16'd0 || 17'(len_full) > MAX_LEN) begin
            state_d = S_ERROR;
            busy_d  = 1'b0;
            error_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          chk_d      = chk_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = in_data;
            2'd1: word_d[15:8]  = in_data;
            2'd2: word_d[23:16] = in_data;
            default: begin
              // Top byte goes straight to the write register; word index doubles as the count.
              we_d    = 1'b1;
              addr_d  = words_q[ADDR_WIDTH-1:0];
              wdata_d = {in_data, word_q};
              words_d = words_q + (ADDR_WIDTH+1)'(1);
              if (last_word) state_d = S_CHECK;
            end
          endcase
        end
      end

      S_CHECK: begin
        if (accept) begin
          busy_d = 1'b0;
          if (in_data == chk_q) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            core_reset_d = 1'b0;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // One-cycle bubble entering CHECK keeps a trailing data byte from being taken as the checksum.
    in_ready_d = (state_d inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK}) &&
                 !(state_q == S_DATA && state_d == S_CHECK);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment; blocking is reserved for the comb block.
    if (reset) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      len_q        <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      chk_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      words_q      <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      len_q        <= len_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      chk_q        <= chk_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      words_q      <= words_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign core_reset   = core_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of frames plus hand sequences; writes are scoreboarded
// against a queue filled by the byte driver and drained by a negedge monitor.
module tb_imem_loader;

  localparam int AW   = 8;
  localparam int MAXW = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_reset   (core_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } sb_t;

  typedef struct {
    string        name;
    int           nbytes;
    logic [127:0] b;        // frame bytes, first byte most significant
    int           max_gap;
    logic         exp_done;
    logic         exp_error;
    logic [AW:0]  exp_words;
  } vec_t;

  sb_t           exp_q[$];
  logic [7:0]    frame_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  bit            mon_en = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [31:0]   last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_status(input string tag, input logic e_busy, input logic e_done,
                              input logic e_err, input logic e_cr, input logic e_rdy,
                              input logic [AW:0] e_words);
    check({tag, ".busy"},         64'(busy),         64'(e_busy));
    check({tag, ".done"},         64'(done),         64'(e_done));
    check({tag, ".error"},        64'(error),        64'(e_err));
    check({tag, ".core_reset"},   64'(core_reset),   64'(e_cr));
    check({tag, ".in_ready"},     64'(in_ready),     64'(e_rdy));
    check({tag, ".words_loaded"}, 64'(words_loaded), 64'(e_words));
  endtask

  task automatic check_idle(input string tag);
    check_status(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check({tag, ".imem_we"},    64'(imem_we),    64'(0));
    check({tag, ".imem_addr"},  64'(imem_addr),  64'(0));
    check({tag, ".imem_wdata"}, 64'(imem_wdata), 64'(0));
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // All drive tasks are entered and left at posedge+1.
  task automatic pulse_start();
    start = 1'b1;
    align();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) begin
      in_data = 8'($urandom);
      align();
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 40) begin
        check("ready_timeout", 64'(in_ready), 64'(1));
        break;
      end
    end
    align();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Sends frame_q; the reference model predicts each word write from the frame itself.
  task automatic send_frame(input int max_gap);
    int          n;
    bit          ok;
    int          k;
    logic [31:0] w;
    n  = (frame_q.size() >= 2) ? int'({frame_q[1], frame_q[0]}) : 0;
    ok = (n != 0) && (n <= MAXW);
    w  = '0;
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i], (max_gap > 0) ? int'($urandom_range(1, max_gap)) : 0);
      if (ok && i >= 2 && i < 2 + 4 * n) begin
        k = (i - 2) % 4;
        w[8*k +: 8] = frame_q[i];
        if (k == 3) exp_q.push_back('{addr: AW'((i - 2) / 4), data: w, cyc: cyc});
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    sb_t e;
    if (mon_en) begin
      if (reset) begin
        last_addr = '0;
        last_data = '0;
      end else if (imem_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", 64'(imem_we), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("we_addr",    64'(imem_addr),  64'(e.addr));
          check("we_data",    64'(imem_wdata), 64'(e.data));
          check("we_latency", 64'(cyc),        64'(e.cyc));
        end
        last_addr = imem_addr;
        last_data = imem_wdata;
      end else begin
        check("addr_hold",  64'(imem_addr),  64'(last_addr));
        check("wdata_hold", 64'(imem_wdata), 64'(last_data));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[6];
    logic [7:0]  chk;
    logic [31:0] d;
    logic [7:0]  bt;

    vecs[0] = '{"good2",     11, 128'h02_00_44_33_22_11_A5_A5_A5_A5_44, 0, 1'b1, 1'b0, 9'd2};
    vecs[1] = '{"bad_chk",   11, 128'h02_00_44_33_22_11_A5_A5_A5_A5_45, 0, 1'b0, 1'b1, 9'd2};
    vecs[2] = '{"len_zero",   2, 128'h00_00,                            0, 1'b0, 1'b1, 9'd0};
    vecs[3] = '{"len_257",    2, 128'h01_01,                            0, 1'b0, 1'b1, 9'd0};
    vecs[4] = '{"gap_good",   7, 128'h01_00_B3_01_11_00_A3,             3, 1'b1, 1'b0, 9'd1};
    vecs[5] = '{"gap_bad",    7, 128'h01_00_B3_01_11_00_B3,             3, 1'b0, 1'b1, 9'd1};

    // Reset, then idle.
    reset = 1'b1;
    repeat (2) align();
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (5) align();
    @(negedge clk);
    check_idle("reset");
    align();

    for (int v = 0; v < 6; v++) begin
      pulse_start();
      @(negedge clk);
      check_status({vecs[v].name, ".start"}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, '0);
      align();
      frame_q.delete();
      for (int i = 0; i < vecs[v].nbytes; i++)
        frame_q.push_back(vecs[v].b[8*(vecs[v].nbytes - 1 - i) +: 8]);
      send_frame(vecs[v].max_gap);
      @(negedge clk);
      check_status(vecs[v].name, 1'b0, vecs[v].exp_done, vecs[v].exp_error,
                   !vecs[v].exp_done, 1'b0, vecs[v].exp_words);
      check({vecs[v].name, ".sb_drained"}, 64'(exp_q.size()), 64'(0));
      align();
    end

    // Largest legal frame: MAXW words, then the bubble before CHK.
    pulse_start();
    frame_q.delete();
    frame_q.push_back(8'(MAXW % 256));
    frame_q.push_back(8'(MAXW / 256));
    chk = 8'h00;
    for (int w = 0; w < MAXW; w++) begin
      d = $urandom;
      for (int k = 0; k < 4; k++) begin
        bt = d[8*k +: 8];
        frame_q.push_back(bt);
        chk = chk ^ bt;
      end
    end
    send_frame(0);
    @(negedge clk);
    check("max.chk_bubble_ready", 64'(in_ready), 64'(0));
    check("max.busy_before_chk",  64'(busy),     64'(1));
    align();
    send_byte(chk, 0);
    @(negedge clk);
    check_status("max", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (AW+1)'(MAXW));
    align();

    // Reset in the cycle the third data byte is accepted.
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    in_valid = 1'b1;
    in_data  = 8'h33;
    reset    = 1'b1;
    @(negedge clk);
    check("midrst.ready_at_reset", 64'(in_ready), 64'(1));
    align();
    reset   = 1'b0;
    in_data = 8'h44;
    @(negedge clk);
    check_idle("midrst");
    repeat (3) align();
    @(negedge clk);
    check("midrst.ready_later", 64'(in_ready), 64'(0));
    check("midrst.words_later", 64'(words_loaded), 64'(0));
    align();
    in_valid = 1'b0;

    // start while busy is ignored.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    pulse_start();
    @(negedge clk);
    check_status("busy_start", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    align();
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    exp_q.push_back('{addr: AW'(0), data: 32'hEFBE_ADDE, cyc: cyc});
    send_byte(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF, 0);
    @(negedge clk);
    check_status("busy_start_end", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd1);
    align();

    // start in DONE re-asserts core_reset on the next edge.
    pulse_start();
    @(negedge clk);
    check_status("restart", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    align();

    reset = 1'b1;
    align();
    reset = 1'b0;
    repeat (2) align();
    check("final.sb_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
